column_readout: RTL

COLUMN_READOUT -- requirements
Module: column_readout

---
 rtl/column_readout.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/column_readout.sv
// Streams one column of the node memory out over a valid/ready port after each compute step.
// It also captures the centre node as the audio sample and flags a start that arrives mid-stream.
module column_readout #(
  parameter int NUM_ROWS   = 30,
  parameter int CENTER_ROW = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [4:0]  mem_rd_addr,
  output logic        mem_rd_en,
  input  logic [17:0] mem_rd_data,
  output logic [17:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic [17:0] center_sample,
  output logic        center_valid,
  output logic        overrun,
  output logic [1:0]  dbg_state
);

  // Output handshake: a word transfers in every cycle where out_valid and out_ready are
  // both high. While out_valid is high and out_ready is low, out_data and out_last hold.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [5:0] LAST_ROW   = 6'(NUM_ROWS - 1);
  localparam logic [5:0] CENTER_IDX = 6'(CENTER_ROW);

  state_t      state_q, state_d;
  logic [5:0]  rd_ptr_q, rd_ptr_d;
  logic [5:0]  out_idx_q, out_idx_d;
  logic        inflight_q, inflight_d;
  logic [1:0]  count_q, count_d;
  logic [17:0] buf0_q, buf0_d;
  logic [17:0] buf1_q, buf1_d;
  logic [17:0] center_q, center_d;
  logic        center_valid_q, center_valid_d;
  logic        overrun_q, overrun_d;

  logic        pop;
  logic        issue;
  logic [1:0]  occ_after_pop;

  // The head word comes from the buffer when it holds data; otherwise a word returning
  // from memory is presented directly, so node 0 is visible two cycles after start.
  always_comb begin
    out_valid     = (count_q != 2'd0) || inflight_q;
    out_data      = (count_q != 2'd0) ? buf0_q : (inflight_q ? mem_rd_data : 18'd0);
    out_last      = out_valid && (out_idx_q == LAST_ROW);
    pop           = out_valid && out_ready;
    occ_after_pop = count_q + {1'b0, inflight_q} - {1'b0, pop};
    issue         = (state_q == READ) && (occ_after_pop < 2'd2);
    mem_rd_en     = issue;
    mem_rd_addr   = rd_ptr_q[4:0];
    busy          = (state_q != IDLE);
    center_sample = center_q;
    center_valid  = center_valid_q;
    overrun       = overrun_q;
    dbg_state     = state_q;
  end

  always_comb begin
    state_d        = state_q;
    rd_ptr_d       = rd_ptr_q;
    out_idx_d      = out_idx_q;
    overrun_d      = overrun_q;
    center_d       = center_q;
    center_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = READ;
          rd_ptr_d  = 6'd0;
          out_idx_d = 6'd0;
        end
      end
      READ: begin
        if (issue) begin
          rd_ptr_d = rd_ptr_q + 6'd1;
          if (rd_ptr_q == LAST_ROW) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && out_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A start outside IDLE, including the cycle the last word leaves, is dropped.
    if (start && (state_q != IDLE)) overrun_d = 1'b1;

    if (pop) begin
      out_idx_d = out_idx_q + 6'd1;
      if (out_idx_q == CENTER_IDX) begin
        center_d       = out_data;
        center_valid_d = 1'b1;
      end
    end
  end

  // Two-entry buffer: entry 0 is the head. The issue rule keeps buffered plus
  // in-flight words at two or fewer, so a full buffer never has a word in flight.
  always_comb begin
    count_d    = occ_after_pop;
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    inflight_d = issue;
    case (count_q)
      2'd0: begin
        if (inflight_q && !pop) buf0_d = mem_rd_data;
      end
      2'd1: begin
        if (inflight_q && pop)       buf0_d = mem_rd_data;
        else if (inflight_q && !pop) buf1_d = mem_rd_data;
      end
      default: begin
        if (pop) buf0_d = buf1_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      rd_ptr_q       <= 6'd0;
      out_idx_q      <= 6'd0;
      inflight_q     <= 1'b0;
      count_q        <= 2'd0;
      buf0_q         <= 18'd0;
      buf1_q         <= 18'd0;
      center_q       <= 18'd0;
      center_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      rd_ptr_q       <= rd_ptr_d;
      out_idx_q      <= out_idx_d;
      inflight_q     <= inflight_d;
      count_q        <= count_d;
      buf0_q         <= buf0_d;
      buf1_q         <= buf1_d;
      center_q       <= center_d;
      center_valid_q <= center_valid_d;
      overrun_q      <= overrun_d;
    end
  end

endmodule
